pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for a five-stage pipeline: generates stage enables,
// flush/bubble/redirect controls, memory-wait freeze and drain-to-halt sequencing.
module pipeline_ctrl #(
   parameter int CNT_W     = 32,
   parameter int DRAIN_CYC = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             data_hazard,
   input  logic             ctrl_hazard,
   input  logic             ex_resolve,
   input  logic             ex_taken,
   input  logic             dmem_ready,
   input  logic             halt_req,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             pc_redirect,
   output logic             halted,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int DC_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   typedef enum logic [2:0] {
      RUN       = 3'd0,
      CTRL_WAIT = 3'd1,
      MEM_WAIT  = 3'd2,
      DRAIN     = 3'd3,
      HALTED    = 3'd4
   } state_t;

   state_t            state_q, state_d;
   state_t            saved_q, saved_d;
   logic [DC_W-1:0]   drain_q, drain_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              cnt_inc;

   // Outputs are a pure function of the current state and this cycle's inputs;
   // the same decode also produces the next-state values.
   always_comb begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pc_redirect = 1'b0;
      halted      = 1'b0;
      state_d     = state_q;
      saved_d     = saved_q;
      drain_d     = drain_q;

      if (!rst_n) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else begin
         case (state_q)
            HALTED: begin
               halted = 1'b1;
               if (!halt_req)
                  state_d = RUN;
            end
            // The return cycle stays fully frozen; restored outputs start next cycle.
            MEM_WAIT: begin
               if (dmem_ready)
                  state_d = saved_q;
            end
            default: begin
               if (!dmem_ready) begin
                  saved_d = state_q;
                  state_d = MEM_WAIT;
               end else begin
                  case (state_q)
                     RUN: begin
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                        if (data_hazard) begin
                           idex_bubble = 1'b1;
                        end else if (ctrl_hazard) begin
                           ifid_en    = 1'b1;
                           ifid_flush = 1'b1;
                           state_d    = CTRL_WAIT;
                        end else if (halt_req) begin
                           ifid_flush  = 1'b1;
                           idex_bubble = 1'b1;
                           drain_d     = DC_W'(DRAIN_CYC - 1);
                           state_d     = DRAIN;
                        end else begin
                           pc_en   = 1'b1;
                           ifid_en = 1'b1;
                        end
                     end
                     CTRL_WAIT: begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                        if (ex_resolve) begin
                           pc_en       = 1'b1;
                           pc_redirect = ex_taken;
                           state_d     = RUN;
                        end
                     end
                     DRAIN: begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                        if (drain_q == '0)
                           state_d = HALTED;
                        else
                           drain_d = drain_q - 1'b1;
                     end
                     default: state_d = RUN;
                  endcase
               end
            end
         endcase
      end
   end

   // Stall cycles are fetch-blocked cycles while the pipeline is live; saturates.
   assign cnt_inc = !pc_en && (state_q != HALTED) && (cnt_q != '1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         saved_q <= RUN;
         drain_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         saved_q <= saved_d;
         drain_q <= drain_d;
         if (cnt_inc)
            cnt_q <= cnt_q + 1'b1;
      end
   end

   assign state     = state_q;
   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model of the controller.
module tb_pipeline_ctrl;

   localparam int CNT_W     = 4;
   localparam int DRAIN_CYC = 3;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             data_hazard = 1'b0;
   logic             ctrl_hazard = 1'b0;
   logic             ex_resolve = 1'b0;
   logic             ex_taken = 1'b0;
   logic             dmem_ready = 1'b1;
   logic             halt_req = 1'b0;
   logic             pc_en, ifid_en, exmem_en, memwb_en;
   logic             ifid_flush, idex_bubble, pc_redirect, halted;
   logic [2:0]       state;
   logic [CNT_W-1:0] stall_cnt;

   int tests_run = 0;
   int tests_failed = 0;

   // Behavioural model: state numbers as the spec defines them.
   int m_state = 0;
   int m_saved = 0;
   int m_drain_left = 0;
   int m_stalls = 0;

   always #5 clk = ~clk;

   pipeline_ctrl #(.CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)) dut (
      .clk(clk), .rst_n(rst_n),
      .data_hazard(data_hazard), .ctrl_hazard(ctrl_hazard),
      .ex_resolve(ex_resolve), .ex_taken(ex_taken),
      .dmem_ready(dmem_ready), .halt_req(halt_req),
      .pc_en(pc_en), .ifid_en(ifid_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
      .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pc_redirect(pc_redirect),
      .halted(halted), .state(state), .stall_cnt(stall_cnt)
   );

   // Expected {pc_en, ifid_en, exmem_en, memwb_en, ifid_flush, idex_bubble, pc_redirect, halted}
   function automatic logic [7:0] model_outputs();
      if (!rst_n) return 8'b0000_1100;
      if (m_state == 4) return 8'b0000_0001;
      if (m_state == 2 || !dmem_ready) return 8'b0000_0000;
      if (m_state == 1)
         return ex_resolve ? {6'b1011_11, ex_taken, 1'b0} : 8'b0011_1100;
      if (m_state == 3) return 8'b0011_1100;
      if (data_hazard) return 8'b0011_0100;
      if (ctrl_hazard) return 8'b0111_1000;
      if (halt_req) return 8'b0011_1100;
      return 8'b1111_0000;
   endfunction

   function automatic void model_reset();
      m_state = 0;
      m_saved = 0;
      m_drain_left = 0;
      m_stalls = 0;
   endfunction

   function automatic void model_advance();
      logic [7:0] exp;
      if (!rst_n) return;
      exp = model_outputs();
      if (m_state != 4 && !exp[7])
         m_stalls = (m_stalls + 1 > CNT_MAX) ? CNT_MAX : m_stalls + 1;
      if (m_state == 4) begin
         if (!halt_req) m_state = 0;
      end else if (m_state == 2) begin
         if (dmem_ready) m_state = m_saved;
      end else if (!dmem_ready) begin
         m_saved = m_state;
         m_state = 2;
      end else if (m_state == 1) begin
         if (ex_resolve) m_state = 0;
      end else if (m_state == 3) begin
         if (m_drain_left == 0) m_state = 4;
         else m_drain_left = m_drain_left - 1;
      end else if (!data_hazard && ctrl_hazard) begin
         m_state = 1;
      end else if (!data_hazard && halt_req) begin
         m_drain_left = DRAIN_CYC - 1;
         m_state = 3;
      end
   endfunction

   task automatic check(input string name, input int actual, input int expected);
      tests_run++;
      if (actual != expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkOutput();
      check("outputs", int'({pc_en, ifid_en, exmem_en, memwb_en,
                             ifid_flush, idex_bubble, pc_redirect, halted}),
            int'(model_outputs()));
      check("state", int'(state), m_state);
      check("stall_cnt", int'(stall_cnt), m_stalls);
   endtask

   task automatic applyStimulus(input bit dh, input bit ch, input bit er,
                                input bit et, input bit dr, input bit hr);
      @(negedge clk);
      data_hazard = dh;
      ctrl_hazard = ch;
      ex_resolve  = er;
      ex_taken    = et;
      dmem_ready  = dr;
      halt_req    = hr;
      #2;
      checkOutput();
   endtask

   task automatic step_clock();
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(input bit dh, input bit ch, input bit er,
                        input bit et, input bit dr, input bit hr);
      applyStimulus(dh, ch, er, et, dr, hr);
      step_clock();
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      model_reset();
      checkOutput();
      @(posedge clk);
      #1;
      checkOutput();
      rst_n = 1'b1;
   endtask

   function automatic bit chance(input int pct);
      return $urandom_range(0, 99) < pct;
   endfunction

   initial begin
      int drain_seen;

      // Reset values pinned by hand.
      #2;
      check("rst_state", int'(state), 0);
      check("rst_stall_cnt", int'(stall_cnt), 0);
      check("rst_pc_en", int'(pc_en), 0);
      check("rst_flush_bubble", int'({ifid_flush, idex_bubble}), 3);
      do_reset();

      // Two-cycle data hazard.
      applyStimulus(1, 0, 0, 0, 1, 0);
      check("dh_c0_en", int'({pc_en, ifid_en, idex_bubble}), 1);
      step_clock();
      applyStimulus(1, 0, 0, 0, 1, 0);
      check("dh_c1_en", int'({pc_en, ifid_en, idex_bubble}), 1);
      step_clock();
      check("dh_stall_cnt", int'(stall_cnt), 2);
      applyStimulus(0, 0, 0, 0, 1, 0);
      check("dh_resume", int'({pc_en, ifid_en, exmem_en, memwb_en}), 15);
      step_clock();

      // Branch in ID, then taken resolve.
      applyStimulus(0, 1, 0, 0, 1, 0);
      check("br_c0", int'({pc_en, ifid_flush}), 1);
      step_clock();
      applyStimulus(0, 0, 1, 1, 1, 0);
      check("br_c1", int'({state, pc_en, pc_redirect}), 7);
      step_clock();
      applyStimulus(0, 0, 0, 0, 1, 0);
      check("br_c2", int'({state, pc_redirect}), 0);
      step_clock();

      // Memory wait during CTRL_WAIT, then resolve not-taken.
      cycle(0, 1, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0);
         check("mw_en", int'({pc_en, ifid_en, exmem_en, memwb_en}), 0);
         if (i == 1) check("mw_state", int'(state), 2);
         step_clock();
      end
      applyStimulus(0, 0, 0, 0, 1, 0);
      check("mw_return", int'({pc_en, ifid_en, exmem_en, memwb_en, ifid_flush, idex_bubble}), 0);
      step_clock();
      applyStimulus(0, 0, 1, 0, 1, 0);
      check("mw_restored", int'({state, pc_en, pc_redirect}), 6);
      step_clock();
      applyStimulus(0, 0, 0, 0, 1, 0);
      check("mw_run", int'(state), 0);
      step_clock();

      // Drain and halt.
      cycle(0, 0, 0, 0, 1, 1);
      drain_seen = 0;
      for (int i = 0; i < 8 && state != 3'd4; i++) begin
         applyStimulus(0, 0, 0, 0, 1, 1);
         if (state == 3'd3) drain_seen++;
         step_clock();
      end
      check("drain_cycles", drain_seen, 3);
      applyStimulus(0, 0, 0, 0, 1, 1);
      check("halted_hold", int'({state, halted}), 9);
      step_clock();
      applyStimulus(0, 0, 0, 0, 1, 0);
      check("halted_release", int'({state, halted}), 9);
      step_clock();
      applyStimulus(0, 0, 0, 0, 1, 0);
      check("halt_to_run", int'({state, halted}), 0);
      step_clock();

      // Dropping halt_req mid-drain still passes through HALTED.
      cycle(0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 1, 0);
         check("drain_noabort", int'(state), 3);
         step_clock();
      end
      applyStimulus(0, 0, 0, 0, 1, 0);
      check("drain_halted", int'({state, halted}), 9);
      step_clock();

      // Stall counter saturation.
      do_reset();
      for (int i = 0; i < 15; i++) cycle(1, 0, 0, 0, 1, 0);
      check("sat_preload", int'(stall_cnt), 15);
      cycle(1, 0, 0, 0, 1, 0);
      cycle(1, 0, 0, 0, 1, 0);
      check("sat_hold", int'(stall_cnt), 15);

      // Asynchronous reset in mid-drain.
      do_reset();
      cycle(0, 0, 0, 0, 1, 1);
      cycle(0, 0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 1, 1);
      rst_n = 1'b0;
      #1;
      check("async_state", int'(state), 0);
      check("async_stall_cnt", int'(stall_cnt), 0);
      check("async_outputs", int'({pc_en, ifid_flush, idex_bubble}), 3);
      model_reset();
      checkOutput();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Randomized traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         cycle(chance(20), chance(20), chance(35), chance(50), !chance(15), chance(12));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
